sequential_alu: RTL and testbench
=================================

# sequential_alu

Parametrised, handshaked successor to the datapath ALU. It adds a width parameter, a half-width/full-width mode bit, rotate-through-carry and a multi-cycle shift-add multiply. Results and flags are registered. Operands enter on a valid/ready handshake, and results leave on a second valid/ready handshake with backpressure. It sits between the register-file read ports and the writeback mux, under control-unit sequencing.

## Interface
- WIDTH, 16, datapath width; even, ≥ 4; half width H = WIDTH/2
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- InValid  in  1  operation presented
- InReady  out  1  block can accept; combinational
- A, B  in  WIDTH  operands
- FunSel  in  5  bit 4: 1 = full width, 0 = half width; bits 3:0 = opcode
- WF  in  1  write flags for this operation
- OutValid  out  1  ALUOut valid
- OutReady  in  1  consumer takes result
- ALUOut  out  WIDTH  registered result
- FlagsOut  out  4  registered {Z, C, N, O}, bit 3 = Z
- Busy  out  1  multiply in progress

## Operation
- Operation width is N = WIDTH if FunSel[4] = 1, else H.
- Half-width mode uses A[H-1:0] and B[H-1:0]. ALUOut upper H bits are 0.
- Opcodes 0–F:
  - 0: A
  - 1: B
  - 2: ~A
  - 3: ~B
  - 4: A+B
  - 5: A+B+C
  - 6: A−B, computed as A + ~B + 1
  - 7: AND
  - 8: OR
  - 9: XOR
  - A: NAND
  - B: LSL
  - C: LSR
  - D: ASR
  - E: CSL, rotate left through carry: {A[N-2:0], C}
  - F: MUL, unsigned; result is the low N bits of the product
- Flags are computed at width N:
  - Z: result == 0
  - N: result[N-1]
  - C for 4/5/6: carry-out of bit N-1. For 6, C = 1 means no borrow.
  - C for LSL and CSL: the bit shifted out of A[N-1]. For LSR and ASR: A[0].
  - C for MUL: 1 if the high N product bits are nonzero.
  - C for 0–3 and 7–A: unchanged.
  - O: signed overflow for 4/5/6; 0 for all other opcodes.
- ADC (opcode 5) uses the FlagsOut.C value present in the accept cycle.
- FlagsOut is written only when WF was 1 at accept. With WF = 0, FlagsOut holds.
- FSM states:
  - IDLE → MUL on accepting opcode F.
  - MUL → IDLE when the iteration count reaches N.
  - Single-cycle opcodes stay in IDLE.
- InReady = (state == IDLE) && (!OutValid || OutReady).
- Accept occurs when InValid && InReady. A, B, FunSel and WF are captured at accept.
- Busy = (state == MUL).

## Timing
- Reset values: ALUOut 0, FlagsOut 0000, OutValid 0, state IDLE, iteration counter 0. InReady is therefore 1 during and after reset.
- Single-cycle opcodes:
  - The result is computed from the live inputs.
  - ALUOut and flags load on the accept edge, so OutValid is high in the next cycle (latency 1).
  - Back-to-back accepts sustain one operation per cycle while OutReady = 1.
  - A following ADC sees the updated carry.
- MUL:
  - Performs N shift-add iterations, one per cycle.
  - ALUOut and flags load on the N-th edge after accept, so OutValid rises N cycles after accept.
  - InReady is 0 throughout the MUL state.
- Result handshake:
  - OutValid holds until a cycle with OutReady = 1.
  - ALUOut and FlagsOut are stable while OutValid && !OutReady.
  - If OutReady = 1 in the same cycle as a new accept, the new result replaces the old one with no bubble.
  - OutValid falls on the edge where OutReady is seen with no new result loading.
- Reset asserted mid-MUL aborts the operation: no result is produced, FlagsOut = 0000 and the partial product is discarded.
- Shifts by construction move one position only; no shift-amount input.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_LDA … OP_MUL)
  - flag bit indices (FLAG_Z = 3, FLAG_C = 2, FLAG_N = 1, FLAG_O = 0)
  - the FSM state typedef {IDLE, MUL}
- Sub-module alu_shift_add_mul, parametrised by WIDTH:
  - inputs: start, width select, operands
  - outputs: product low/high and a done pulse after N iterations
- The top module owns the handshake, the flag register and the combinational single-cycle datapath.

## Test plan
All scenarios use WIDTH = 16.
- Reset/abort: Reset low during cycle 5 of a MUL → OutValid 0, FlagsOut 0000, InReady 1. After release, no stale result appears.
- ADD overflow: A = 0x7FFF, B = 0x0001, FunSel = 10100, WF = 1 → next cycle ALUOut 0x8000, FlagsOut 0011. Then SUB A = B = 0x0005 → ALUOut 0x0000, FlagsOut 1100.
- Half-width ADC with carry chain, starting from C = 1: A = 0x12FF, B = 0x0001, FunSel = 00101 → ALUOut 0x0001, FlagsOut 0100. Then CSL full with A = 0x8001 → ALUOut 0x0003, C = 1.
- WF = 0: XOR of A = 0xFFFF with B = 0xFFFF → ALUOut 0x0000, FlagsOut unchanged.
- MUL: A = 0x0100, B = 0x0100 full → InReady 0 for 16 cycles, OutValid at cycle 16, ALUOut 0x0000, FlagsOut 1100. Half-width 0x0F × 0x0F → 0x00E1 after 8 cycles.
- Backpressure: hold OutReady = 0 for 3 cycles with InValid = 1 → ALUOut stable, InReady 0. The next operation is accepted in the cycle OutReady rises, and its result appears the following cycle.

Source files
------------

// File: rtl/sequential_alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - opcode encodings (FunSel[3:0])
//   - bit position of the width-select bit inside FunSel
//   - flag bit indices inside FlagsOut ({Z, C, N, O}, Z is bit 3)
//   - FSM state type for the top-level sequencer
//   - helper that packs individual flag bits into the 4-bit flag word
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_LDB  = 4'h1;
  localparam logic [3:0] OP_NOTA = 4'h2;
  localparam logic [3:0] OP_NOTB = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_LSL  = 4'hB;
  localparam logic [3:0] OP_LSR  = 4'hC;
  localparam logic [3:0] OP_ASR  = 4'hD;
  localparam logic [3:0] OP_CSL  = 4'hE;
  localparam logic [3:0] OP_MUL  = 4'hF;

  localparam int FUNSEL_W = 5;
  localparam int FULL_BIT = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic n, input logic o);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_O] = o;
    return f;
  endfunction

endpackage

// File: rtl/sequential_alu_if.sv
// -----------------------------------------------------------------------------
// sequential_alu_if
// Operand and result handshake bundle of the sequential ALU.
//   in_valid / in_ready   : operand handshake (in_ready is combinational)
//   a, b                  : operands, WIDTH bits
//   fun_sel               : bit 4 = full width, bits 3:0 = opcode
//   wf                    : update flags for this operation
//   out_valid / out_ready : result handshake with backpressure
//   alu_out, flags_out    : registered result and {Z, C, N, O}
//   busy                  : multiply in progress
// master = register-file / control side, slave = the ALU.
// -----------------------------------------------------------------------------
interface sequential_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       fun_sel;
  logic             wf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags_out;
  logic             busy;

  modport master (
    output in_valid, a, b, fun_sel, wf, out_ready,
    input  in_ready, out_valid, alu_out, flags_out, busy
  );

  modport slave (
    input  in_valid, a, b, fun_sel, wf, out_ready,
    output in_ready, out_valid, alu_out, flags_out, busy
  );
endinterface

// File: rtl/sequential_alu_shift_add_mul.sv
// -----------------------------------------------------------------------------
// alu_shift_add_mul
// Unsigned iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load operands and begin (one-cycle pulse)
//   i_full         : 1 = WIDTH-bit operation, 0 = WIDTH/2-bit operation
//   i_a, i_b       : operands (upper half ignored in half-width mode)
//   o_prod_lo      : low N bits of the product (zero-extended in half mode)
//   o_prod_hi      : high N bits of the product (zero-extended in half mode)
//   o_done         : high during the cycle performing the N-th iteration;
//                    o_prod_lo/hi already include that iteration, so the
//                    consumer can register them on the N-th edge after start
// -----------------------------------------------------------------------------
module alu_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_full,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic             o_done
);
  localparam int H     = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               r_active;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_full;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0]   w_last_cnt;
  logic               w_last;

  assign w_a = i_full ? i_a : {{H{1'b0}}, i_a[H-1:0]};
  assign w_b = i_full ? i_b : {{H{1'b0}}, i_b[H-1:0]};

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last_cnt = r_full ? CNT_W'(WIDTH - 1) : CNT_W'(H - 1);
  assign w_last     = r_active && (r_cnt == w_last_cnt);

  // Iteration control: cleared by reset so an aborted multiply leaves no trace
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Partial-product datapath
  always_ff @(posedge i_clk) begin
    if (i_start) begin
      r_full   <= i_full;
      r_mcand  <= {{WIDTH{1'b0}}, w_a};
      r_mplier <= w_b;
      r_acc    <= '0;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

  // In half mode the whole product fits in the low WIDTH bits of the accumulator
  assign o_prod_lo = r_full ? w_acc_next[WIDTH-1:0]
                            : {{H{1'b0}}, w_acc_next[H-1:0]};
  assign o_prod_hi = r_full ? w_acc_next[2*WIDTH-1:WIDTH]
                            : {{H{1'b0}}, w_acc_next[WIDTH-1:H]};
  assign o_done    = w_last;

endmodule

// File: rtl/sequential_alu.sv
// -----------------------------------------------------------------------------
// sequential_alu
// Handshaked, width-parametrised ALU with registered result and flags.
// Single-cycle opcodes are computed from the live operands and registered on
// the accept edge; MUL runs N shift-add iterations in alu_shift_add_mul.
// Ports:
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset (aborts a multiply in flight)
//   io_bus   : sequential_alu_if slave modport (operand/result handshakes,
//              fun_sel, wf, alu_out, flags_out {Z,C,N,O}, busy)
// -----------------------------------------------------------------------------
module sequential_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sequential_alu_if.slave       io_bus
);
  localparam int H     = WIDTH / 2;
  localparam int IDX_W = $clog2(WIDTH);

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;

  logic [WIDTH-1:0] r_res_p1;
  logic [3:0]       r_flags_p1;
  logic             r_vld_p1;
  logic             r_wf_mul;
  logic             r_full_mul;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_load_single;
  logic             w_mul_fin;

  logic             w_full;
  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_mask;
  logic [IDX_W-1:0] w_msb;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_a_msb;

  logic [WIDTH-1:0] w_add_b;
  logic             w_add_ci;
  logic [WIDTH:0]   w_sum;
  logic             w_add_c;
  logic             w_add_ovf;

  logic [WIDTH-1:0] w_sign_fill;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_o;
  logic [3:0]       w_flags_new;

  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_mul_hi;
  logic             w_mul_done;
  logic [IDX_W-1:0] w_mul_msb;
  logic [3:0]       w_mul_flags;

  // Operand conditioning: half-width mode works on zero-extended low halves
  assign w_full  = io_bus.fun_sel[FULL_BIT];
  assign w_op    = io_bus.fun_sel[3:0];
  assign w_mask  = w_full ? {WIDTH{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
  assign w_msb   = w_full ? IDX_W'(WIDTH - 1) : IDX_W'(H - 1);
  assign w_a     = io_bus.a & w_mask;
  assign w_b     = io_bus.b & w_mask;
  assign w_cin   = r_flags_p1[FLAG_C];
  assign w_a_msb = w_a[w_msb];

  // Shared adder for ADD/ADC/SUB; SUB is A + ~B + 1 with ~B confined to N bits
  assign w_add_b  = (w_op == OP_SUB) ? (~io_bus.b & w_mask) : w_b;
  assign w_add_ci = (w_op == OP_SUB) ? 1'b1 : ((w_op == OP_ADC) ? w_cin : 1'b0);
  assign w_sum    = {1'b0, w_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_ci};
  // Operands are zero above N, so the carry out of bit N-1 lands in bit N
  assign w_add_c  = w_full ? w_sum[WIDTH] : w_sum[H];
  assign w_add_ovf = (w_a_msb == w_add_b[w_msb]) && (w_sum[w_msb] != w_a_msb);

  assign w_sign_fill = w_a_msb ? (WIDTH'(1) << w_msb) : '0;

  always_comb begin
    w_raw = '0;
    w_c   = w_cin;
    w_o   = 1'b0;
    case (w_op)
      OP_LDA:  w_raw = w_a;
      OP_LDB:  w_raw = w_b;
      OP_NOTA: w_raw = ~w_a;
      OP_NOTB: w_raw = ~w_b;
      OP_ADD, OP_ADC, OP_SUB: begin
        w_raw = w_sum[WIDTH-1:0];
        w_c   = w_add_c;
        w_o   = w_add_ovf;
      end
      OP_AND:  w_raw = w_a & w_b;
      OP_OR:   w_raw = w_a | w_b;
      OP_XOR:  w_raw = w_a ^ w_b;
      OP_NAND: w_raw = ~(w_a & w_b);
      OP_LSL: begin
        w_raw = {w_a[WIDTH-2:0], 1'b0};
        w_c   = w_a_msb;
      end
      OP_LSR: begin
        w_raw = {1'b0, w_a[WIDTH-1:1]};
        w_c   = w_a[0];
      end
      OP_ASR: begin
        w_raw = {1'b0, w_a[WIDTH-1:1]} | w_sign_fill;
        w_c   = w_a[0];
      end
      OP_CSL: begin
        w_raw = {w_a[WIDTH-2:0], w_cin};
        w_c   = w_a_msb;
      end
      default: w_raw = '0;
    endcase
  end

  assign w_res       = w_raw & w_mask;
  assign w_flags_new = pack_flags(w_res == '0, w_c, w_res[w_msb], w_o);

  alu_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mul_start),
    .i_full    (w_full),
    .i_a       (io_bus.a),
    .i_b       (io_bus.b),
    .o_prod_lo (w_mul_lo),
    .o_prod_hi (w_mul_hi),
    .o_done    (w_mul_done)
  );

  assign w_mul_msb   = r_full_mul ? IDX_W'(WIDTH - 1) : IDX_W'(H - 1);
  assign w_mul_flags = pack_flags(w_mul_lo == '0, w_mul_hi != '0,
                                  w_mul_lo[w_mul_msb], 1'b0);

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_in_ready    = 1'b0;
    w_busy        = 1'b0;
    w_accept      = 1'b0;
    w_mul_start   = 1'b0;
    w_load_single = 1'b0;
    w_mul_fin     = 1'b0;
    case (r_state)
      IDLE: begin
        // A pending result blocks new work unless it is consumed this cycle
        w_in_ready = !r_vld_p1 || io_bus.out_ready;
        w_accept   = io_bus.in_valid && w_in_ready;
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = MUL;
          end else begin
            w_load_single = 1'b1;
          end
        end
      end
      MUL: begin
        w_busy = 1'b1;
        if (w_mul_done) begin
          w_mul_fin   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiply context captured at accept, consumed when the product lands
  always_ff @(posedge i_clk) begin
    if (w_mul_start) begin
      r_wf_mul   <= io_bus.wf;
      r_full_mul <= w_full;
    end
  end

  // Stage p1: registered result, flags and result-valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_p1   <= '0;
      r_flags_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else if (w_load_single) begin
      r_res_p1 <= w_res;
      r_vld_p1 <= 1'b1;
      if (io_bus.wf) r_flags_p1 <= w_flags_new;
    end else if (w_mul_fin) begin
      r_res_p1 <= w_mul_lo;
      r_vld_p1 <= 1'b1;
      if (r_wf_mul) r_flags_p1 <= w_mul_flags;
    end else if (io_bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.busy      = w_busy;
  assign io_bus.out_valid = r_vld_p1;
  assign io_bus.alu_out   = r_res_p1;
  assign io_bus.flags_out = r_flags_p1;

endmodule

// File: tb/tb_sequential_alu.sv
// -----------------------------------------------------------------------------
// tb_sequential_alu
// Directed and randomised checks of sequential_alu at WIDTH = 16 against an
// arithmetic reference model (integer math on N-bit values, signed ranges for
// overflow, plain multiplication for MUL).
// -----------------------------------------------------------------------------
module tb_sequential_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] m_flags;

  sequential_alu_if #(.WIDTH(16)) bus ();

  sequential_alu #(.WIDTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: returns {result[15:0], flags[3:0]}
  function automatic logic [19:0] ref_op(input logic [3:0] op, input bit full,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] fin);
    int     n    = full ? 16 : 8;
    longint m    = (longint'(1) << n) - 1;
    longint half = longint'(1) << (n - 1);
    longint x    = longint'(a) & m;
    longint y    = longint'(b) & m;
    longint sx   = (x >= half) ? x - (m + 1) : x;
    longint sy   = (y >= half) ? y - (m + 1) : y;
    longint ci   = longint'(fin[2]);
    longint r    = 0;
    longint s    = 0;
    bit     c    = fin[2];
    bit     o    = 1'b0;
    case (op)
      4'h0: r = x;
      4'h1: r = y;
      4'h2: r = m - x;
      4'h3: r = m - y;
      4'h4: begin r = x + y;      c = (r > m); s = sx + sy;      o = (s >= half) || (s < -half); end
      4'h5: begin r = x + y + ci; c = (r > m); s = sx + sy + ci; o = (s >= half) || (s < -half); end
      4'h6: begin r = x - y;      c = (x >= y); s = sx - sy;     o = (s >= half) || (s < -half); end
      4'h7: r = x & y;
      4'h8: r = x | y;
      4'h9: r = x ^ y;
      4'hA: r = m - (x & y);
      4'hB: begin r = x * 2;      c = (x >= half); end
      4'hC: begin r = x / 2;      c = x[0]; end
      4'hD: begin r = sx >>> 1;   c = x[0]; end
      4'hE: begin r = x * 2 + ci; c = (x >= half); end
      default: begin r = x * y;   c = ((r >> n) != 0); end
    endcase
    r = r & m;
    return {r[15:0], (r == 0), c, (r >= half), o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation with OutReady = 1, waits for its result and checks it
  task automatic issue(input logic [3:0] op, input bit full, input logic [15:0] a,
                       input logic [15:0] b, input bit wf, input string tag);
    logic [19:0] exp;
    int cnt;
    bit saw_ready;
    exp = ref_op(op, full, a, b, m_flags);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.fun_sel   = {full, op};
    bus.wf        = wf;
    bus.out_ready = 1'b1;
    #1;
    check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    if (op == 4'hF) begin
      check({tag, ":busy"}, 32'(bus.busy), 32'd1);
      cnt = 0;
      saw_ready = 1'b0;
      while (!bus.out_valid && cnt < 40) begin
        if (bus.in_ready) saw_ready = 1'b1;
        tick();
        cnt++;
      end
      check({tag, ":latency"}, 32'(cnt), full ? 32'd16 : 32'd8);
      check({tag, ":ready_in_mul"}, 32'(saw_ready), 32'd0);
    end
    if (wf) m_flags = exp[3:0];
    check({tag, ":out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ":alu_out"}, 32'(bus.alu_out), 32'(exp[19:4]));
    check({tag, ":flags"}, 32'(bus.flags_out), 32'(m_flags));
  endtask

  initial begin
    logic [15:0] corner [6];
    logic [3:0]  op;
    bit          full;
    bit          wf;
    bit          stale;
    logic [15:0] ra;
    logic [15:0] rb;
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF, 16'h0080};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.fun_sel   = '0;
    bus.wf        = 1'b0;
    bus.out_ready = 1'b1;
    m_flags       = 4'b0000;

    tick();
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:alu_out", 32'(bus.alu_out), 32'd0);
    check("rst:flags", 32'(bus.flags_out), 32'd0);
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("rst:busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(4'h4, 1'b1, 16'h7FFF, 16'h0001, 1'b1, "add_ovf");
    check("add_ovf:spec_out", 32'(bus.alu_out), 32'h8000);
    check("add_ovf:spec_flags", 32'(bus.flags_out), 32'b0011);
    issue(4'h6, 1'b1, 16'h0005, 16'h0005, 1'b1, "sub_zero");
    check("sub_zero:spec_flags", 32'(bus.flags_out), 32'b1100);
    issue(4'h5, 1'b0, 16'h12FF, 16'h0001, 1'b1, "adc_half");
    check("adc_half:spec_out", 32'(bus.alu_out), 32'h0001);
    check("adc_half:spec_flags", 32'(bus.flags_out), 32'b0100);
    issue(4'hE, 1'b1, 16'h8001, 16'h0000, 1'b1, "csl_full");
    check("csl_full:spec_out", 32'(bus.alu_out), 32'h0003);
    issue(4'h9, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "xor_nowf");
    check("xor_nowf:spec_flags", 32'(bus.flags_out), 32'b0100);
    issue(4'hF, 1'b1, 16'h0100, 16'h0100, 1'b1, "mul_full");
    check("mul_full:spec_flags", 32'(bus.flags_out), 32'b1100);
    issue(4'hF, 1'b0, 16'h000F, 16'h000F, 1'b1, "mul_half");
    check("mul_half:spec_out", 32'(bus.alu_out), 32'h00E1);

    // Backpressure: result held while the consumer stalls
    issue(4'h7, 1'b1, 16'hF0F0, 16'hFF00, 1'b1, "bp_first");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h00FF;
    bus.fun_sel   = {1'b1, 4'h8};
    bus.wf        = 1'b0;
    #1;
    check("bp:in_ready_stall0", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp:hold_out%0d", i), 32'(bus.alu_out), 32'hF000);
      check($sformatf("bp:hold_vld%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp:hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp:in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp:next_out", 32'(bus.alu_out), 32'h12FF);
    check("bp:next_vld", 32'(bus.out_valid), 32'd1);
    check("bp:next_flags", 32'(bus.flags_out), 32'(m_flags));

    // Reset during a multiply discards it
    bus.in_valid = 1'b1;
    bus.a        = 16'h0003;
    bus.b        = 16'h0005;
    bus.fun_sel  = {1'b1, 4'hF};
    bus.wf       = 1'b1;
    #1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_flags = 4'b0000;
    check("abort:out_valid", 32'(bus.out_valid), 32'd0);
    check("abort:flags", 32'(bus.flags_out), 32'd0);
    check("abort:in_ready", 32'(bus.in_ready), 32'd1);
    check("abort:busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) stale = 1'b1;
    end
    check("abort:no_stale", 32'(stale), 32'd0);

    // Randomised operations, corner operands mixed in
    for (int i = 0; i < 150; i++) begin
      op   = 4'($urandom_range(0, 15));
      full = 1'($urandom_range(0, 1));
      wf   = ($urandom_range(0, 3) != 0);
      ra   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      issue(op, full, ra, rb, wf, $sformatf("rnd%0d_op%0h_f%0d", i, op, full));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
